multi_song_timer: RTL and testbench

- Parametrised successor to the two-song elapsed-time counter: NUM_CH independent mm:ss play-time counters, one per song.
- Runs on the system clock with a 1 Hz tick enable instead of a derived 1 Hz clock.
- Adds selectable retain/clear-on-switch mode, wrap/saturate mode, per-channel clear, and a rollover pulse.
- Sits between the song selector / pause logic and the seven-segment display mux.

---
 rtl/musicbox_pkg.sv | 13 +
 rtl/multi_song_timer_if.sv | 27 ++
 rtl/mmss_cell.sv | 61 ++++++
 rtl/multi_song_timer.sv | 78 +++++++
 tb/tb_multi_song_timer.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/musicbox_pkg.sv
// Shared constants and types for the music-box play-time counters.
package musicbox_pkg;

  localparam int unsigned SEC_W    = 6;
  localparam int unsigned MIN_W    = 6;
  localparam int unsigned SECS_MAX = 59;

  typedef struct packed {
    logic [MIN_W-1:0] mins;
    logic [SEC_W-1:0] secs;
  } mmss_t;

endpackage

// File: rtl/multi_song_timer_if.sv
// Control and readout bundle between song selector, timer and display mux.
interface multi_song_timer_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned SEL_W  = 4
) ();

  logic                  tick_1hz;
  logic [SEL_W-1:0]      sel;
  logic                  sound_off;
  logic                  clr_sel;
  logic [NUM_CH*6-1:0]   mins_all;
  logic [NUM_CH*6-1:0]   secs_all;
  logic [5:0]            sel_mins;
  logic [5:0]            sel_secs;
  logic                  rollover;

  modport master (
    output tick_1hz, sel, sound_off, clr_sel,
    input  mins_all, secs_all, sel_mins, sel_secs, rollover
  );

  modport slave (
    input  tick_1hz, sel, sound_off, clr_sel,
    output mins_all, secs_all, sel_mins, sel_secs, rollover
  );

endinterface

// File: rtl/mmss_cell.sv
// Single mm:ss play-time counter with wrap or sticky-saturate behaviour.
module mmss_cell
  import musicbox_pkg::*;
#(
  parameter int unsigned MAX_MINS = 59
) (
  input  logic             clk,
  input  logic             RESET_N,
  input  logic             inc,
  input  logic             clr,
  input  logic             hold_sat,
  output logic [MIN_W-1:0] mins,
  output logic [SEC_W-1:0] secs,
  output logic             wrap
);

  mmss_t cnt_q, cnt_d;
  logic  sat_q, sat_d;
  logic  secs_top;
  logic  mins_top;

  always_comb begin
    secs_top = (cnt_q.secs == SEC_W'(SECS_MAX));
    mins_top = (cnt_q.mins == MIN_W'(MAX_MINS));
    cnt_d    = cnt_q;
    sat_d    = sat_q;
    wrap     = 1'b0;
    if (clr) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (inc) begin
      if (!secs_top) begin
        cnt_d.secs = cnt_q.secs + SEC_W'(1);
      end else if (!mins_top) begin
        cnt_d.mins = cnt_q.mins + MIN_W'(1);
        cnt_d.secs = '0;
      end else if (hold_sat) begin
        // Only the first tick that finds the counter pinned reports it.
        wrap  = !sat_q;
        sat_d = 1'b1;
      end else begin
        cnt_d = '0;
        wrap  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!RESET_N) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign mins = cnt_q.mins;
  assign secs = cnt_q.secs;

endmodule

// File: rtl/multi_song_timer.sv
// NUM_CH independent song play-time counters with selected-channel readout
// and a registered rollover pulse.
module multi_song_timer
  import musicbox_pkg::*;
#(
  parameter int unsigned NUM_CH          = 2,
  parameter int unsigned MAX_MINS        = 59,
  parameter int unsigned CLEAR_ON_SWITCH = 1,
  parameter int unsigned SATURATE        = 0,
  parameter int unsigned SEL_W           = 4
) (
  input  logic               clk,
  input  logic               RESET_N,
  multi_song_timer_if.slave  bus
);

  logic [NUM_CH-1:0] sel_hit;
  logic [NUM_CH-1:0] ch_inc;
  logic [NUM_CH-1:0] ch_clr;
  logic [NUM_CH-1:0] ch_wrap;
  logic [MIN_W-1:0]  ch_mins [NUM_CH];
  logic [SEC_W-1:0]  ch_secs [NUM_CH];
  logic              run_tick;
  logic [MIN_W-1:0]  mux_mins;
  logic [SEC_W-1:0]  mux_secs;
  logic              rollover_q;

  // An out-of-range sel hits no channel, so nothing counts or clears.
  assign run_tick = bus.tick_1hz && !bus.sound_off && (|sel_hit);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign sel_hit[k] = (bus.sel == SEL_W'(k));
    assign ch_inc[k]  = run_tick && sel_hit[k] && !bus.clr_sel;
    assign ch_clr[k]  = (bus.clr_sel && sel_hit[k]) ||
                        ((CLEAR_ON_SWITCH != 0) && run_tick && !sel_hit[k]);

    mmss_cell #(
      .MAX_MINS (MAX_MINS)
    ) u_cell (
      .clk      (clk),
      .RESET_N  (RESET_N),
      .inc      (ch_inc[k]),
      .clr      (ch_clr[k]),
      .hold_sat (SATURATE != 0),
      .mins     (ch_mins[k]),
      .secs     (ch_secs[k]),
      .wrap     (ch_wrap[k])
    );

    assign bus.mins_all[6*k +: 6] = ch_mins[k];
    assign bus.secs_all[6*k +: 6] = ch_secs[k];
  end

  always_comb begin
    mux_mins = '0;
    mux_secs = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel_hit[k]) begin
        mux_mins = ch_mins[k];
        mux_secs = ch_secs[k];
      end
    end
  end

  assign bus.sel_mins = mux_mins;
  assign bus.sel_secs = mux_secs;

  always_ff @(posedge clk) begin
    if (!RESET_N) begin
      rollover_q <= 1'b0;
    end else begin
      rollover_q <= |ch_wrap;
    end
  end

  assign bus.rollover = rollover_q;

endmodule

// File: tb/tb_multi_song_timer.sv
// Directed bench for multi_song_timer across four parameter builds sharing stimulus.
module tb_multi_song_timer;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic [3:0] sel;
  logic       soff;
  logic       clr;
  int         n_checks;
  int         n_fail;

  multi_song_timer_if #(.NUM_CH(2), .SEL_W(4)) bus_a ();
  multi_song_timer_if #(.NUM_CH(2), .SEL_W(4)) bus_k ();
  multi_song_timer_if #(.NUM_CH(2), .SEL_W(4)) bus_w ();
  multi_song_timer_if #(.NUM_CH(2), .SEL_W(4)) bus_s ();

  assign bus_a.tick_1hz = tick;  assign bus_a.sel = sel;
  assign bus_a.sound_off = soff; assign bus_a.clr_sel = clr;
  assign bus_k.tick_1hz = tick;  assign bus_k.sel = sel;
  assign bus_k.sound_off = soff; assign bus_k.clr_sel = clr;
  assign bus_w.tick_1hz = tick;  assign bus_w.sel = sel;
  assign bus_w.sound_off = soff; assign bus_w.clr_sel = clr;
  assign bus_s.tick_1hz = tick;  assign bus_s.sel = sel;
  assign bus_s.sound_off = soff; assign bus_s.clr_sel = clr;

  multi_song_timer #(
    .NUM_CH(2), .MAX_MINS(59), .CLEAR_ON_SWITCH(1), .SATURATE(0), .SEL_W(4)
  ) dut_a (.clk(clk), .RESET_N(rst_n), .bus(bus_a));

  multi_song_timer #(
    .NUM_CH(2), .MAX_MINS(59), .CLEAR_ON_SWITCH(0), .SATURATE(0), .SEL_W(4)
  ) dut_k (.clk(clk), .RESET_N(rst_n), .bus(bus_k));

  multi_song_timer #(
    .NUM_CH(2), .MAX_MINS(1), .CLEAR_ON_SWITCH(1), .SATURATE(0), .SEL_W(4)
  ) dut_w (.clk(clk), .RESET_N(rst_n), .bus(bus_w));

  multi_song_timer #(
    .NUM_CH(2), .MAX_MINS(1), .CLEAR_ON_SWITCH(1), .SATURATE(1), .SEL_W(4)
  ) dut_s (.clk(clk), .RESET_N(rst_n), .bus(bus_s));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    repeat (n) step();
    tick = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; tick = 1'b0; clr = 1'b0; soff = 1'b0; sel = 4'd0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick = 1'b1; sel = 4'd0; soff = 1'b0; clr = 1'b0;
    step();
    step();
    n_checks++;
    if (bus_a.mins_all !== 12'd0) begin
      n_fail++; $display("FAIL reset_mins: got %0d expected 0", bus_a.mins_all);
    end
    n_checks++;
    if (bus_a.secs_all !== 12'd0) begin
      n_fail++; $display("FAIL reset_secs: got %0d expected 0", bus_a.secs_all);
    end
    n_checks++;
    if (bus_a.rollover !== 1'b0) begin
      n_fail++; $display("FAIL reset_rollover: got %0b expected 0", bus_a.rollover);
    end
    rst_n = 1'b1;
    tick = 1'b0;
    ticks(5);
    n_checks++;
    if (bus_a.secs_all[5:0] !== 6'd5) begin
      n_fail++; $display("FAIL first5_ch0: got %0d expected 5", bus_a.secs_all[5:0]);
    end
    n_checks++;
    if (bus_a.secs_all[11:6] !== 6'd0) begin
      n_fail++; $display("FAIL first5_ch1: got %0d expected 0", bus_a.secs_all[11:6]);
    end
    n_checks++;
    if (bus_a.sel_secs !== 6'd5) begin
      n_fail++; $display("FAIL first5_selsecs: got %0d expected 5", bus_a.sel_secs);
    end
  endtask

  task automatic test_count_pause();
    apply_reset();
    ticks(119);
    n_checks++;
    if (bus_a.mins_all[5:0] !== 6'd1 || bus_a.secs_all[5:0] !== 6'd59) begin
      n_fail++;
      $display("FAIL preload_0159: got %0d:%0d expected 1:59",
               bus_a.mins_all[5:0], bus_a.secs_all[5:0]);
    end
    ticks(1);
    n_checks++;
    if (bus_a.sel_mins !== 6'd2 || bus_a.sel_secs !== 6'd0) begin
      n_fail++;
      $display("FAIL minute_carry: got %0d:%0d expected 2:0", bus_a.sel_mins, bus_a.sel_secs);
    end
    soff = 1'b1;
    ticks(10);
    soff = 1'b0;
    n_checks++;
    if (bus_a.mins_all[5:0] !== 6'd2 || bus_a.secs_all[5:0] !== 6'd0) begin
      n_fail++;
      $display("FAIL pause_hold: got %0d:%0d expected 2:0",
               bus_a.mins_all[5:0], bus_a.secs_all[5:0]);
    end
  endtask

  task automatic test_switch();
    apply_reset();
    ticks(7);
    sel = 4'd1;
    ticks(1);
    n_checks++;
    if (bus_a.secs_all[11:6] !== 6'd1 || bus_a.secs_all[5:0] !== 6'd0) begin
      n_fail++;
      $display("FAIL switch_clear: got ch1=%0d ch0=%0d expected ch1=1 ch0=0",
               bus_a.secs_all[11:6], bus_a.secs_all[5:0]);
    end
    n_checks++;
    if (bus_k.secs_all[11:6] !== 6'd1 || bus_k.secs_all[5:0] !== 6'd7) begin
      n_fail++;
      $display("FAIL switch_retain: got ch1=%0d ch0=%0d expected ch1=1 ch0=7",
               bus_k.secs_all[11:6], bus_k.secs_all[5:0]);
    end
    sel = 4'd0;
    soff = 1'b1;
    ticks(2);
    soff = 1'b0;
    n_checks++;
    if (bus_a.secs_all[11:6] !== 6'd1) begin
      n_fail++;
      $display("FAIL pause_no_clear: got ch1=%0d expected 1", bus_a.secs_all[11:6]);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    ticks(119);
    n_checks++;
    if (bus_w.mins_all[5:0] !== 6'd1 || bus_w.secs_all[5:0] !== 6'd59) begin
      n_fail++;
      $display("FAIL wrap_preload: got %0d:%0d expected 1:59",
               bus_w.mins_all[5:0], bus_w.secs_all[5:0]);
    end
    tick = 1'b1;
    step();
    tick = 1'b0;
    n_checks++;
    if (bus_w.sel_mins !== 6'd0 || bus_w.sel_secs !== 6'd0 || bus_w.rollover !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_edge: got %0d:%0d ro=%0b expected 0:0 ro=1",
               bus_w.sel_mins, bus_w.sel_secs, bus_w.rollover);
    end
    n_checks++;
    if (bus_s.sel_mins !== 6'd1 || bus_s.sel_secs !== 6'd59 || bus_s.rollover !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_edge: got %0d:%0d ro=%0b expected 1:59 ro=1",
               bus_s.sel_mins, bus_s.sel_secs, bus_s.rollover);
    end
    step();
    n_checks++;
    if (bus_w.rollover !== 1'b0 || bus_s.rollover !== 1'b0) begin
      n_fail++;
      $display("FAIL rollover_width: got wrap=%0b sat=%0b expected 0 0",
               bus_w.rollover, bus_s.rollover);
    end
    for (int i = 0; i < 3; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      n_checks++;
      if (bus_s.rollover !== 1'b0 || bus_s.sel_secs !== 6'd59 || bus_s.sel_mins !== 6'd1) begin
        n_fail++;
        $display("FAIL sat_hold_%0d: got %0d:%0d ro=%0b expected 1:59 ro=0",
                 i, bus_s.sel_mins, bus_s.sel_secs, bus_s.rollover);
      end
      n_checks++;
      if (bus_w.rollover !== 1'b0 || bus_w.sel_secs !== 6'(i + 1)) begin
        n_fail++;
        $display("FAIL wrap_after_%0d: got secs=%0d ro=%0b expected secs=%0d ro=0",
                 i, bus_w.sel_secs, bus_w.rollover, i + 1);
      end
      step();
    end
  endtask

  task automatic test_clr();
    apply_reset();
    sel = 4'd1;
    ticks(5);
    sel = 4'd0;
    ticks(30);
    clr = 1'b1;
    tick = 1'b1;
    step();
    clr = 1'b0;
    tick = 1'b0;
    n_checks++;
    if (bus_a.mins_all[5:0] !== 6'd0 || bus_a.secs_all[5:0] !== 6'd0) begin
      n_fail++;
      $display("FAIL clr_beats_tick: got %0d:%0d expected 0:0",
               bus_a.mins_all[5:0], bus_a.secs_all[5:0]);
    end
    n_checks++;
    if (bus_k.secs_all[5:0] !== 6'd0 || bus_k.secs_all[11:6] !== 6'd5) begin
      n_fail++;
      $display("FAIL clr_only_sel: got ch0=%0d ch1=%0d expected ch0=0 ch1=5",
               bus_k.secs_all[5:0], bus_k.secs_all[11:6]);
    end
    ticks(2);
    sel = 4'd3;
    ticks(4);
    n_checks++;
    if (bus_a.secs_all !== 12'd2 || bus_a.mins_all !== 12'd0) begin
      n_fail++;
      $display("FAIL bad_sel_hold: got secs_all=%0d mins_all=%0d expected 2 0",
               bus_a.secs_all, bus_a.mins_all);
    end
    n_checks++;
    if (bus_a.sel_mins !== 6'd0 || bus_a.sel_secs !== 6'd0 || bus_a.rollover !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_sel_readout: got %0d:%0d ro=%0b expected 0:0 ro=0",
               bus_a.sel_mins, bus_a.sel_secs, bus_a.rollover);
    end
    sel = 4'd0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    sel = 4'd1;
    ticks(44);
    n_checks++;
    if (bus_a.secs_all[11:6] !== 6'd44) begin
      n_fail++; $display("FAIL mid_preload: got %0d expected 44", bus_a.secs_all[11:6]);
    end
    rst_n = 1'b0;
    tick = 1'b1;
    step();
    rst_n = 1'b1;
    tick = 1'b0;
    n_checks++;
    if (bus_a.secs_all[11:6] !== 6'd0) begin
      n_fail++; $display("FAIL reset_over_tick: got %0d expected 0", bus_a.secs_all[11:6]);
    end
    ticks(45);
    #2 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    step();
    n_checks++;
    if (bus_a.secs_all[11:6] !== 6'd45) begin
      n_fail++; $display("FAIL reset_glitch: got %0d expected 45", bus_a.secs_all[11:6]);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0; tick = 1'b0; sel = 4'd0; soff = 1'b0; clr = 1'b0;
    test_reset();
    test_count_pause();
    test_switch();
    test_wrap();
    test_clr();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
